// File: rtl/ctrl_pipeline_if.sv
// rtl/ctrl_pipeline_if.sv - RV32I control word package and pipeline control interface
//
// rv32i_pkg      : opcode constants and the decoded rv32i_control_word.
// ctrl_pipeline_if
//   master : ID/datapath side. Drives id_ctrl, id_rs1/2, id_rd, ex_br_taken,
//            imem_stall and dmem_stall. Reads the per-stage control words and
//            rd indices, stall/flush, forwarding selects, wb_we and the
//            commit stream.
//   slave  : ctrl_pipeline side, with the same signals in the opposite directions.
`timescale 1ns/1ps

package rv32i_pkg;
  localparam logic [6:0] op_lui   = 7'b0110111;
  localparam logic [6:0] op_auipc = 7'b0010111;
  localparam logic [6:0] op_jal   = 7'b1101111;
  localparam logic [6:0] op_jalr  = 7'b1100111;
  localparam logic [6:0] op_br    = 7'b1100011;
  localparam logic [6:0] op_load  = 7'b0000011;
  localparam logic [6:0] op_store = 7'b0100011;
  localparam logic [6:0] op_imm   = 7'b0010011;
  localparam logic [6:0] op_reg   = 7'b0110011;

  // An all-zero word is a bubble.
  typedef struct packed {
    logic       valid;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       mem_read;
    logic       mem_write;
    logic       load_regfile;
  } rv32i_control_word;
endpackage

interface ctrl_pipeline_if #(parameter int ORDER_W = 64);
  rv32i_pkg::rv32i_control_word id_ctrl;
  logic [4:0]                   id_rs1;
  logic [4:0]                   id_rs2;
  logic [4:0]                   id_rd;
  logic                         ex_br_taken;
  logic                         imem_stall;
  logic                         dmem_stall;
  rv32i_pkg::rv32i_control_word ex_ctrl;
  rv32i_pkg::rv32i_control_word mem_ctrl;
  rv32i_pkg::rv32i_control_word wb_ctrl;
  logic [4:0]                   ex_rd;
  logic [4:0]                   mem_rd;
  logic [4:0]                   wb_rd;
  logic                         stall_if_id;
  logic                         flush_if_id;
  logic [1:0]                   fwd_a_sel;
  logic [1:0]                   fwd_b_sel;
  logic                         wb_we;
  logic                         commit_valid;
  logic [ORDER_W-1:0]           commit_order;

  modport master (
    output id_ctrl, id_rs1, id_rs2, id_rd, ex_br_taken, imem_stall, dmem_stall,
    input  ex_ctrl, mem_ctrl, wb_ctrl, ex_rd, mem_rd, wb_rd, stall_if_id,
           flush_if_id, fwd_a_sel, fwd_b_sel, wb_we, commit_valid, commit_order
  );

  modport slave (
    input  id_ctrl, id_rs1, id_rs2, id_rd, ex_br_taken, imem_stall, dmem_stall,
    output ex_ctrl, mem_ctrl, wb_ctrl, ex_rd, mem_rd, wb_rd, stall_if_id,
           flush_if_id, fwd_a_sel, fwd_b_sel, wb_we, commit_valid, commit_order
  );
endinterface

// File: rtl/ctrl_pipeline.sv
// rtl/ctrl_pipeline.sv - EX/MEM/WB control word pipeline with hazard, forwarding and commit logic
//
// Carries the decoded control word from ID through EX, MEM and WB. It raises
// stall/flush for IF/ID on hazards and redirects. It produces the EX operand
// forwarding selects, the regfile write enable and the RVFI commit stream.
//
// Ports:
//   clk : clock. All state changes on the rising edge.
//   rst : asynchronous active-low reset.
//   bus : ctrl_pipeline_if.slave (ID inputs, stall inputs, stage/hazard/commit outputs).
//
// Build option CTRL_PIPE_FWD_EN:
//   defined   : MEM/WB to EX forwarding is enabled. Only a load-use hazard stalls.
//   undefined : the forwarding selects are tied to 00. Any RAW dependency on a
//               valid EX or MEM writer stalls ID.
`timescale 1ns/1ps

module ctrl_pipeline
  import rv32i_pkg::*;
#(
  parameter int ORDER_W = 64
) (
  input logic            clk,
  input logic            rst,
  ctrl_pipeline_if.slave bus
);

  rv32i_control_word  r_ex_ctrl;
  rv32i_control_word  r_mem_ctrl;
  rv32i_control_word  r_wb_ctrl;
  logic [4:0]         r_ex_rd;
  logic [4:0]         r_mem_rd;
  logic [4:0]         r_wb_rd;
  logic [ORDER_W-1:0] r_commit_order;

  logic w_gs;
  logic w_use_rs1;
  logic w_use_rs2;
  logic w_ex_wr;
  logic w_mem_wr;
  logic w_wb_wr;
  logic w_id_hit_ex;
  logic w_hazard;
  logic w_redirect;
  logic w_bubble;

  function automatic logic f_uses_rs1(input rv32i_control_word c);
    return c.valid && (c.opcode != op_lui) && (c.opcode != op_auipc) &&
           (c.opcode != op_jal);
  endfunction

  function automatic logic f_uses_rs2(input rv32i_control_word c);
    return c.valid && ((c.opcode == op_br) || (c.opcode == op_store) ||
                       (c.opcode == op_reg));
  endfunction

  assign w_gs      = bus.imem_stall | bus.dmem_stall;
  assign w_use_rs1 = f_uses_rs1(bus.id_ctrl);
  assign w_use_rs2 = f_uses_rs2(bus.id_ctrl);

  // A stage "writes" only if it holds a real instruction targeting a non-x0 register.
  assign w_ex_wr  = r_ex_ctrl.valid  & r_ex_ctrl.load_regfile  & (r_ex_rd  != 5'd0);
  assign w_mem_wr = r_mem_ctrl.valid & r_mem_ctrl.load_regfile & (r_mem_rd != 5'd0);
  assign w_wb_wr  = r_wb_ctrl.valid  & r_wb_ctrl.load_regfile  & (r_wb_rd  != 5'd0);

  assign w_id_hit_ex = (r_ex_rd != 5'd0) &&
                       ((w_use_rs1 && (bus.id_rs1 == r_ex_rd)) ||
                        (w_use_rs2 && (bus.id_rs2 == r_ex_rd)));

`ifdef CTRL_PIPE_FWD_EN
  logic [4:0] r_ex_rs1;
  logic [4:0] r_ex_rs2;
  logic [1:0] w_fwd_a;
  logic [1:0] w_fwd_b;

  // Only a load in EX cannot be forwarded in time. Every other RAW is covered
  // by the MEM/WB bypass.
  assign w_hazard = r_ex_ctrl.valid & r_ex_ctrl.mem_read & w_id_hit_ex;

  // MEM holds the younger result, so it is checked before WB.
  assign w_fwd_a = (w_mem_wr && (r_mem_rd == r_ex_rs1)) ? 2'b01 :
                   (w_wb_wr  && (r_wb_rd  == r_ex_rs1)) ? 2'b10 : 2'b00;
  assign w_fwd_b = (w_mem_wr && (r_mem_rd == r_ex_rs2)) ? 2'b01 :
                   (w_wb_wr  && (r_wb_rd  == r_ex_rs2)) ? 2'b10 : 2'b00;

  assign bus.fwd_a_sel = w_fwd_a;
  assign bus.fwd_b_sel = w_fwd_b;
`else
  logic w_id_hit_mem;

  assign w_id_hit_mem = (r_mem_rd != 5'd0) &&
                        ((w_use_rs1 && (bus.id_rs1 == r_mem_rd)) ||
                         (w_use_rs2 && (bus.id_rs2 == r_mem_rd)));

  // Without a bypass, ID waits until every pending writer of its sources has
  // reached WB.
  assign w_hazard = (w_ex_wr & w_id_hit_ex) | (w_mem_wr & w_id_hit_mem);

  assign bus.fwd_a_sel = 2'b00;
  assign bus.fwd_b_sel = 2'b00;
`endif

  assign w_redirect = bus.ex_br_taken & r_ex_ctrl.valid & ~w_gs;
  assign w_bubble   = w_redirect | w_hazard;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ex_ctrl      <= '0;
      r_mem_ctrl     <= '0;
      r_wb_ctrl      <= '0;
      r_ex_rd        <= '0;
      r_mem_rd       <= '0;
      r_wb_rd        <= '0;
      r_commit_order <= '0;
`ifdef CTRL_PIPE_FWD_EN
      r_ex_rs1       <= '0;
      r_ex_rs2       <= '0;
`endif
    end else if (!w_gs) begin
      r_wb_ctrl  <= r_mem_ctrl;
      r_wb_rd    <= r_mem_rd;
      r_mem_ctrl <= r_ex_ctrl;
      r_mem_rd   <= r_ex_rd;
      if (w_bubble) begin
        r_ex_ctrl <= '0;
        r_ex_rd   <= '0;
`ifdef CTRL_PIPE_FWD_EN
        r_ex_rs1  <= '0;
        r_ex_rs2  <= '0;
`endif
      end else begin
        r_ex_ctrl <= bus.id_ctrl;
        r_ex_rd   <= bus.id_rd;
`ifdef CTRL_PIPE_FWD_EN
        r_ex_rs1  <= bus.id_rs1;
        r_ex_rs2  <= bus.id_rs2;
`endif
      end
      // Under !gs, a valid WB word is exactly the commit pulse.
      if (r_wb_ctrl.valid) begin
        r_commit_order <= r_commit_order + 1'b1;
      end
    end
  end

  assign bus.ex_ctrl      = r_ex_ctrl;
  assign bus.mem_ctrl     = r_mem_ctrl;
  assign bus.wb_ctrl      = r_wb_ctrl;
  assign bus.ex_rd        = r_ex_rd;
  assign bus.mem_rd       = r_mem_rd;
  assign bus.wb_rd        = r_wb_rd;
  // The combinational outputs are gated so they read 0 while reset is held.
  assign bus.stall_if_id  = rst & (w_gs | (w_hazard & ~w_redirect));
  assign bus.flush_if_id  = rst & w_redirect;
  assign bus.wb_we        = w_wb_wr;
  assign bus.commit_valid = rst & r_wb_ctrl.valid & ~w_gs;
  assign bus.commit_order = r_commit_order;

endmodule
